// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Holds the FSM encoding, port index names and byte-lane helpers.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_RESP = 2'd3
    } state_e;

    localparam logic PORT0   = 1'b0;
    localparam logic PORT1   = 1'b1;

    // Byte address bit 0 picks the lane inside a 16-bit word.
    localparam logic LANE_LO = 1'b0;
    localparam logic LANE_HI = 1'b1;

    function automatic logic [7:0] lane_pick(input logic [15:0] word, input logic lane);
        return (lane == LANE_HI) ? word[15:8] : word[7:0];
    endfunction

    function automatic logic [15:0] lane_merge(input logic [15:0] word, input logic [7:0] b,
                                               input logic lane);
        return (lane == LANE_HI) ? {b, word[7:0]} : {word[15:8], b};
    endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the
// port that was not granted last.
module mem_arb_rr
    import mem_arb_pkg::*;
(
    input  logic req_0,
    input  logic req_1,
    input  logic last_grant,
    output logic grant_vld,
    output logic grant
);

    always_comb begin
        grant_vld = req_0 | req_1;
        grant     = PORT0;
        if (req_0 && req_1) begin
            grant = (last_grant == PORT0) ? PORT1 : PORT0;
        end else if (req_1) begin
            grant = PORT1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a 16-bit synchronous-read memory.
// Byte writes go through a read-modify-write (RD then WR).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req_0,
    input  logic              we_0,
    input  logic              wide_0,
    input  logic [ADDR_W-1:0] addr_0,
    input  logic [15:0]       wdata_0,
    output logic [15:0]       rdata_0,
    output logic              ack_0,

    input  logic              req_1,
    input  logic              we_1,
    input  logic              wide_1,
    input  logic [ADDR_W-1:0] addr_1,
    input  logic [15:0]       wdata_1,
    output logic [15:0]       rdata_1,
    output logic              ack_1,

    output logic [ADDR_W-2:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              mem_we,
    input  logic [15:0]       mem_rdata,

    output logic              busy
);

    state_e            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              port_q, port_d;
    logic              we_q, we_d;
    logic              wide_q, wide_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       wdata_q, wdata_d;

    logic              grant_vld;
    logic              grant;
    logic [15:0]       resp_data;

    mem_arb_rr u_rr (
        .req_0      (req_0),
        .req_1      (req_1),
        .last_grant (last_grant_q),
        .grant_vld  (grant_vld),
        .grant      (grant)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            last_grant_q <= PORT1;
            port_q       <= PORT0;
            we_q         <= 1'b0;
            wide_q       <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            port_q       <= port_d;
            we_q         <= we_d;
            wide_q       <= wide_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        port_d       = port_q;
        we_d         = we_q;
        wide_d       = wide_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (grant_vld) begin
                    port_d       = grant;
                    last_grant_d = grant;
                    we_d         = (grant == PORT1) ? we_1    : we_0;
                    wide_d       = (grant == PORT1) ? wide_1  : wide_0;
                    addr_d       = (grant == PORT1) ? addr_1  : addr_0;
                    wdata_d      = (grant == PORT1) ? wdata_1 : wdata_0;
                    // Only a full-word write can skip the read phase.
                    state_d      = (we_d && wide_d) ? S_WR : S_RD;
                end
            end
            S_RD:    state_d = we_q ? S_WR : S_RESP;
            S_WR:    state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != S_IDLE);
        mem_we    = (state_q == S_WR);
        mem_addr  = (state_q == S_IDLE) ? '0 : addr_q[ADDR_W-1:1];
        mem_wdata = '0;
        if (state_q == S_WR) begin
            // mem_rdata here is the word fetched during RD.
            mem_wdata = wide_q ? wdata_q : lane_merge(mem_rdata, wdata_q[7:0], addr_q[0]);
        end

        resp_data = '0;
        if (!we_q) begin
            resp_data = wide_q ? mem_rdata : {8'h00, lane_pick(mem_rdata, addr_q[0])};
        end

        ack_0   = (state_q == S_RESP) && (port_q == PORT0);
        ack_1   = (state_q == S_RESP) && (port_q == PORT1);
        rdata_0 = ack_0 ? resp_data : '0;
        rdata_1 = ack_1 ? resp_data : '0;
    end

endmodule
